// File: rtl/debounce_multi.sv
// rtl/debounce_multi.sv - multi-channel button debouncer with edge pulses and press counters
// Optional long-press detection is built when DEBOUNCE_MULTI_LONG_PRESS_EN is defined.
module debounce_multi #(
  parameter int N_CH          = 4,
  parameter int STABLE_CYCLES = 1000000,
  parameter int CNT_W         = 8,
  parameter int LONG_CYCLES   = 50000000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [N_CH-1:0]       btn_in,
  input  logic                  count_clr,
  output logic [N_CH-1:0]       btn_level,
  output logic [N_CH-1:0]       btn_rise,
  output logic [N_CH-1:0]       btn_fall,
  output logic [N_CH*CNT_W-1:0] press_count,
  output logic [N_CH-1:0]       btn_long
);

  localparam int STAB_W = $clog2(STABLE_CYCLES);
  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_CYCLES - 1);

`ifdef DEBOUNCE_MULTI_LONG_PRESS_EN
  localparam int LONG_W = $clog2(LONG_CYCLES + 1);
  localparam logic [LONG_W-1:0] LONG_MAX = LONG_W'(LONG_CYCLES);
  localparam logic [LONG_W-1:0] LONG_PRE = LONG_W'(LONG_CYCLES - 1);
`endif

  typedef enum logic [1:0] {
    ST_LOW       = 2'd0,
    ST_WAIT_HIGH = 2'd1,
    ST_HIGH      = 2'd2,
    ST_WAIT_LOW  = 2'd3
  } state_e;

  if (N_CH < 1 || N_CH > 16 || STABLE_CYCLES < 2 || CNT_W < 1 || CNT_W > 16 ||
      LONG_CYCLES < 1) begin : g_bad_params
    $error("debounce_multi: parameter out of range");
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [1:0]        sync_q, sync_d;
    state_e            state_q, state_d;
    logic [STAB_W-1:0] stab_q, stab_d;
    logic              level_q, level_d;
    logic              rise_q, rise_d;
    logic              fall_q, fall_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              sync_in;

    assign sync_in = sync_q[1];

    always_ff @(posedge clock) begin
      if (reset) begin
        sync_q  <= '0;
        state_q <= ST_LOW;
        stab_q  <= '0;
        level_q <= 1'b0;
        rise_q  <= 1'b0;
        fall_q  <= 1'b0;
        cnt_q   <= '0;
      end else begin
        sync_q  <= sync_d;
        state_q <= state_d;
        stab_q  <= stab_d;
        level_q <= level_d;
        rise_q  <= rise_d;
        fall_q  <= fall_d;
        cnt_q   <= cnt_d;
      end
    end

    // The stable state is entered on the edge where the counter would reach STABLE_CYCLES.
    always_comb begin
      sync_d  = {sync_q[0], btn_in[i]};
      state_d = state_q;
      stab_d  = stab_q;
      case (state_q)
        ST_LOW: begin
          if (sync_in) begin
            state_d = ST_WAIT_HIGH;
            stab_d  = STAB_W'(1);
          end
        end
        ST_WAIT_HIGH: begin
          if (!sync_in) begin
            state_d = ST_LOW;
            stab_d  = '0;
          end else if (stab_q == STAB_LAST) begin
            state_d = ST_HIGH;
            stab_d  = '0;
          end else begin
            stab_d  = stab_q + STAB_W'(1);
          end
        end
        ST_HIGH: begin
          if (!sync_in) begin
            state_d = ST_WAIT_LOW;
            stab_d  = STAB_W'(1);
          end
        end
        ST_WAIT_LOW: begin
          if (sync_in) begin
            state_d = ST_HIGH;
            stab_d  = '0;
          end else if (stab_q == STAB_LAST) begin
            state_d = ST_LOW;
            stab_d  = '0;
          end else begin
            stab_d  = stab_q + STAB_W'(1);
          end
        end
        default: begin
          state_d = ST_LOW;
          stab_d  = '0;
        end
      endcase
    end

    // Clear takes precedence over a coincident press.
    always_comb begin
      level_d = (state_d == ST_HIGH) || (state_d == ST_WAIT_LOW);
      rise_d  = (state_q == ST_WAIT_HIGH) && (state_d == ST_HIGH);
      fall_d  = (state_q == ST_WAIT_LOW) && (state_d == ST_LOW);
      if (count_clr) begin
        cnt_d = '0;
      end else if (rise_d) begin
        cnt_d = cnt_q + CNT_W'(1);
      end else begin
        cnt_d = cnt_q;
      end
    end

    assign btn_level[i]                   = level_q;
    assign btn_rise[i]                    = rise_q;
    assign btn_fall[i]                    = fall_q;
    assign press_count[i*CNT_W +: CNT_W]  = cnt_q;

`ifdef DEBOUNCE_MULTI_LONG_PRESS_EN
    logic [LONG_W-1:0] hold_q, hold_d;
    logic              long_q, long_d;

    always_ff @(posedge clock) begin
      if (reset) begin
        hold_q <= '0;
        long_q <= 1'b0;
      end else begin
        hold_q <= hold_d;
        long_q <= long_d;
      end
    end

    // Hold counter saturates at LONG_CYCLES so the pulse fires once per press.
    always_comb begin
      hold_d = '0;
      long_d = 1'b0;
      if (level_q && level_d) begin
        if (hold_q != LONG_MAX) begin
          hold_d = hold_q + LONG_W'(1);
          long_d = (hold_q == LONG_PRE);
        end else begin
          hold_d = hold_q;
        end
      end
    end

    assign btn_long[i] = long_q;
`endif
  end

`ifndef DEBOUNCE_MULTI_LONG_PRESS_EN
  assign btn_long = '0;
`endif

endmodule

// File: tb/tb_debounce_multi.sv
// tb/tb_debounce_multi.sv - directed self-checking bench for debounce_multi
// Long-press expectations follow DEBOUNCE_MULTI_LONG_PRESS_EN.
module tb_debounce_multi;

  localparam int N_CH          = 4;
  localparam int STABLE_CYCLES = 4;
  localparam int CNT_W         = 4;
  localparam int LONG_CYCLES   = 10;
`ifdef DEBOUNCE_MULTI_LONG_PRESS_EN
  localparam int EXP_LONG = 1;
`else
  localparam int EXP_LONG = 0;
`endif

  logic                  clock = 1'b0;
  logic                  reset = 1'b1;
  logic [N_CH-1:0]       btn_in = '0;
  logic                  count_clr = 1'b0;
  logic [N_CH-1:0]       btn_level;
  logic [N_CH-1:0]       btn_rise;
  logic [N_CH-1:0]       btn_fall;
  logic [N_CH*CNT_W-1:0] press_count;
  logic [N_CH-1:0]       btn_long;

  debounce_multi #(
    .N_CH(N_CH), .STABLE_CYCLES(STABLE_CYCLES), .CNT_W(CNT_W), .LONG_CYCLES(LONG_CYCLES)
  ) dut (
    .clock(clock), .reset(reset), .btn_in(btn_in), .count_clr(count_clr),
    .btn_level(btn_level), .btn_rise(btn_rise), .btn_fall(btn_fall),
    .press_count(press_count), .btn_long(btn_long)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;
  logic [N_CH-1:0] level_or, level_and, rise_or, fall_or, long_or;
  int rise_n[N_CH];
  int fall_n[N_CH];
  int long_n[N_CH];
  int long_at;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_tally();
    level_or  = '0;
    level_and = '1;
    rise_or   = '0;
    fall_or   = '0;
    long_or   = '0;
    for (int c = 0; c < N_CH; c++) begin
      rise_n[c] = 0;
      fall_n[c] = 0;
      long_n[c] = 0;
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    level_or  = level_or | btn_level;
    level_and = level_and & btn_level;
    rise_or   = rise_or | btn_rise;
    fall_or   = fall_or | btn_fall;
    long_or   = long_or | btn_long;
    for (int c = 0; c < N_CH; c++) begin
      rise_n[c] += int'(btn_rise[c]);
      fall_n[c] += int'(btn_fall[c]);
      long_n[c] += int'(btn_long[c]);
    end
  endtask

  initial begin
    // Reset with all buttons held high
    clear_tally();
    btn_in = 4'hF;
    repeat (3) tick();
    check_eq("rst_level_any", level_or, 0);
    check_eq("rst_rise_any", rise_or, 0);
    check_eq("rst_fall_any", fall_or, 0);
    check_eq("rst_long_any", long_or, 0);
    check_eq("rst_count", press_count, 0);
    reset = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k == 5) check_eq("rel_rise_e5", btn_rise, 4'h0);
      if (k == 6) begin
        check_eq("rel_rise_e6", btn_rise, 4'hF);
        check_eq("rel_level_e6", btn_level, 4'hF);
        check_eq("rel_count", press_count, 16'h1111);
      end
    end
    tick();
    check_eq("rel_rise_one_cycle", btn_rise, 4'h0);

    // Release all channels
    btn_in = 4'h0;
    repeat (5) tick();
    check_eq("fall_e5_level", btn_level, 4'hF);
    tick();
    check_eq("fall_e6", btn_fall, 4'hF);
    check_eq("fall_e6_level", btn_level, 4'h0);
    tick();
    check_eq("fall_one_cycle", btn_fall, 4'h0);

    count_clr = 1'b1;
    tick();
    count_clr = 1'b0;
    check_eq("count_clr", press_count, 16'h0000);
    check_eq("count_clr_keeps_level", btn_level, 4'h0);

    // ch0 chatter then held high
    clear_tally();
    for (int k = 0; k < 20; k++) begin
      btn_in[0] = (k % 2 == 0);
      tick();
    end
    btn_in[0] = 1'b1;
    repeat (5) tick();
    check_eq("chatter_level_e5", btn_level[0], 1'b0);
    tick();
    check_eq("chatter_level_e6", btn_level[0], 1'b1);
    check_eq("chatter_rise_n", rise_n[0], 1);
    check_eq("chatter_count", press_count, 16'h0001);
    btn_in[0] = 1'b0;
    repeat (8) tick();

    // ch1 short pulse then low glitch while high
    clear_tally();
    btn_in[1] = 1'b1;
    repeat (3) tick();
    btn_in[1] = 1'b0;
    repeat (10) tick();
    check_eq("ch1_short_pulse", {level_or[1], rise_or[1], fall_or[1]}, 3'b000);
    btn_in[1] = 1'b1;
    repeat (8) tick();
    check_eq("ch1_high", btn_level[1], 1'b1);
    clear_tally();
    btn_in[1] = 1'b0;
    tick();
    btn_in[1] = 1'b1;
    repeat (10) tick();
    check_eq("ch1_glitch_edges", {rise_or[1], fall_or[1]}, 2'b00);
    check_eq("ch1_glitch_level", level_and[1], 1'b1);
    btn_in[1] = 1'b0;
    repeat (8) tick();
    check_eq("ch1_low", btn_level[1], 1'b0);

    // 16 clean presses on ch2 wrap its counter
    clear_tally();
    for (int p = 1; p <= 16; p++) begin
      btn_in[2] = 1'b1;
      repeat (7) tick();
      btn_in[2] = 1'b0;
      repeat (7) tick();
      if (p == 15) check_eq("ch2_count_15", press_count, 16'h0F11);
    end
    check_eq("ch2_rise_n", rise_n[2], 16);
    check_eq("ch2_fall_n", fall_n[2], 16);
    check_eq("ch2_count_wrap", press_count, 16'h0011);
    check_eq("ch2_others_quiet", {rise_or & 4'hB, fall_or & 4'hB}, 8'h00);

    // count_clr alongside btn_rise on ch3
    btn_in[3] = 1'b1;
    repeat (6) tick();
    check_eq("ch3_rise", btn_rise, 4'h8);
    check_eq("ch3_count", press_count, 16'h1011);
    count_clr = 1'b1;
    tick();
    count_clr = 1'b0;
    check_eq("clr_after_rise", press_count, 16'h0000);
    btn_in[3] = 1'b0;
    repeat (8) tick();
    btn_in[3] = 1'b1;
    repeat (5) tick();
    count_clr = 1'b1;
    tick();
    count_clr = 1'b0;
    check_eq("clr_wins_rise", btn_rise, 4'h8);
    check_eq("clr_wins_count", press_count, 16'h0000);
    btn_in[3] = 1'b0;
    repeat (8) tick();

    // Reset in the middle of WAIT_HIGH
    clear_tally();
    btn_in[3] = 1'b1;
    repeat (4) tick();
    reset = 1'b1;
    btn_in[3] = 1'b0;
    tick();
    reset = 1'b0;
    repeat (10) tick();
    check_eq("rst_wait_quiet", {level_or[3], rise_or[3], fall_or[3]}, 3'b000);

    // Long press on ch0
    clear_tally();
    btn_in[0] = 1'b1;
    repeat (6) tick();
    check_eq("long_rise", btn_rise[0], 1'b1);
    long_at = -1;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (btn_long[0] && long_at < 0) long_at = k;
    end
    check_eq("long_pulses", long_n[0], EXP_LONG);
`ifdef DEBOUNCE_MULTI_LONG_PRESS_EN
    check_eq("long_delay", long_at, 10);
`endif
    btn_in[0] = 1'b0;
    repeat (8) tick();
    clear_tally();
    btn_in[0] = 1'b1;
    repeat (8) tick();
    btn_in[0] = 1'b0;
    repeat (20) tick();
    check_eq("short_no_long", long_or, 4'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/debounce_multi.md
DEBOUNCE_MULTI -- requirements
Module: debounce_multi

Interface
REQ-001 Parameter N_CH, default 4: number of independent button channels, range 1..16.
REQ-002 Parameter STABLE_CYCLES, default 1000000: consecutive stable synchronized samples required to accept a new level, minimum 2.
REQ-003 Parameter CNT_W, default 8: width of each per-channel press counter, range 1..16.
REQ-004 Parameter LONG_CYCLES, default 50000000: cycles a debounced high level must persist to flag a long press; used only with LONG_PRESS_EN.
REQ-005 clock  input  1  single system clock; all logic on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 btn_in  input  N_CH  raw asynchronous button levels, bit i = channel i.
REQ-008 count_clr  input  1  synchronous clear of all press counters; does not touch debounce state.
REQ-009 btn_level  output  N_CH  debounced level per channel.
REQ-010 btn_rise  output  N_CH  one-cycle pulse on accepted low-to-high transition.
REQ-011 btn_fall  output  N_CH  one-cycle pulse on accepted high-to-low transition.
REQ-012 press_count  output  N_CH*CNT_W  per-channel press counters, channel i at bits [i*CNT_W +: CNT_W].
REQ-013 btn_long  output  N_CH  one-cycle long-press pulse per channel.

Function
REQ-014 Each channel SHALL pass btn_in through a 2-flop synchronizer before any other use; channels SHALL be fully independent.
REQ-015 Each channel SHALL run an FSM with states LOW, WAIT_HIGH, HIGH, WAIT_LOW and a stability counter of width clog2(STABLE_CYCLES).
REQ-016 LOW -> WAIT_HIGH when synchronized input is 1, counter loaded to 1; HIGH -> WAIT_LOW symmetric for input 0.
REQ-017 In WAIT_x, if the synchronized input reverts, the FSM SHALL return to the prior stable state, counter cleared, with no output pulse.
REQ-018 In WAIT_x, counter increments per cycle of the new value; on the edge where it would reach STABLE_CYCLES the FSM SHALL enter the new stable state and update btn_level.
REQ-019 Latency: btn_level SHALL change exactly 2 + STABLE_CYCLES clock edges after a clean input edge held stable.
REQ-020 btn_rise/btn_fall SHALL be high for exactly the one cycle in which btn_level first shows the new value.
REQ-021 press_count[i] SHALL increment by 1 in the btn_rise[i] cycle, wrapping modulo 2^CNT_W (all-ones -> 0).
REQ-022 count_clr SHALL zero all counters next edge; clear wins over a coincident btn_rise.
REQ-023 Glitches shorter than STABLE_CYCLES synchronized samples SHALL produce no change on any output.

Reset
REQ-024 Reset SHALL force synchronizers to 0, FSMs to LOW, stability counters to 0, btn_level/btn_rise/btn_fall/btn_long to 0, press_count to 0.
REQ-025 Reset asserted mid-debounce SHALL abort the wait with no pulse; reset has priority over count_clr and all inputs.
REQ-026 A button held high through reset release SHALL be debounced normally, yielding one btn_rise and press_count = 1.

Configuration
REQ-027 Macro DEBOUNCE_MULTI_LONG_PRESS_EN defined: per-channel hold counter counts HIGH cycles from btn_rise; btn_long[i] pulses once when it reaches LONG_CYCLES, at most once per press; counter cleared on leaving HIGH or on reset.
REQ-028 Macro undefined: no hold counters instantiated, btn_long tied to 0, port list unchanged.

Verification (N_CH=4, STABLE_CYCLES=4, CNT_W=4, LONG_CYCLES=10)
REQ-029 Reset 3 cycles, btn_in=4'hF -> all outputs 0 during reset; btn_rise=4'hF exactly 6 edges after release; press_count = 1 per channel.
REQ-030 ch0 toggling every cycle for 20 cycles then held 1 -> btn_level[0] high 6 edges after last toggle, one btn_rise[0], press_count[0]=1.
REQ-031 ch1 high pulse 3 cycles, and 1-cycle low glitch while HIGH -> no btn_level/rise/fall change.
REQ-032 16 clean presses on ch2 -> 16 rise and 16 fall pulses; press_count[2] reads 15 then 0; other channels unaffected.
REQ-033 count_clr in same cycle as btn_rise[3] -> press_count[3]=0 next cycle; reset asserted during WAIT_HIGH -> no pulse, level stays 0.
REQ-034 DEBOUNCE_MULTI_LONG_PRESS_EN defined, ch0 held 30 cycles after rise -> single btn_long[0] pulse 10 cycles after btn_rise[0]; release before 10 -> none; macro undefined -> btn_long always 0.
